// File: rtl/pico_mem_mmio_slave_if.sv
// pico_mem_mmio_slave_if: picorv32 native memory bus (valid/ready) bundled with the
// byte-output stream drained by a valid/ready sink.
interface pico_mem_mmio_slave_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, out_ready,
        input  mem_ready, mem_rdata, bus_err, out_byte, out_valid
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, out_ready,
        output mem_ready, mem_rdata, bus_err, out_byte, out_valid
    );
endinterface

// File: rtl/pico_mem_mmio_slave.sv
// pico_mem_mmio_slave: word RAM plus byte-output FIFO and status register on the picorv32 bus.
// Define PICO_MEM_TIMER_EN to add a free-running cycle counter readable at STAT_ADDR+4.
module pico_mem_mmio_slave #(
    parameter int          MEM_WORDS  = 4096,
    parameter int          READ_WAIT  = 0,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] OUT_ADDR   = 32'h1000_0000,
    parameter logic [31:0] STAT_ADDR  = 32'h1000_0004
) (
    input  logic                 clk,
    input  logic                 resetn,
    pico_mem_mmio_slave_if.slave bus
);
    localparam int              AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int              PW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = PW + 1;
    localparam logic [1:0]      WAIT_CYC    = 2'(READ_WAIT);
    localparam logic [29:0]     MEM_WORDS_W = 30'(MEM_WORDS);
    localparam logic [CW-1:0]   DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1'b1);
    localparam logic [PW-1:0]   PTR_ONE     = PW'(1'b1);
`ifdef PICO_MEM_TIMER_EN
    localparam logic [31:0]     TIMER_ADDR  = STAT_ADDR + 32'd4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        T_RAM   = 3'd0,
        T_OUT   = 3'd1,
        T_STAT  = 3'd2,
        T_TIMER = 3'd3,
        T_ERR   = 3'd4
    } tgt_t;

    state_t          state_r, state_nxt_s;
    tgt_t            tgt_r, tgt_s;
    logic [AW-1:0]   ram_idx_r;
    logic [31:0]     wdata_r;
    logic [3:0]      wstrb_r;
    logic [1:0]      wait_cnt_r;
    logic [31:0]     mmio_q_r;
    logic [31:0]     ram_q_r;
    logic            mem_ready_r;
    logic [31:0]     mem_rdata_r;
    logic            bus_err_r;

    logic [31:0]     ram_r [0:MEM_WORDS-1];
    logic [7:0]      fifo_r [0:FIFO_DEPTH-1];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0]   count_r, count_nxt_s;
    logic [7:0]      out_byte_r, head_nxt_s;
    logic            out_valid_r;

    logic            start_s, is_write_s, wait_done_s, commit_s;
    logic            push_s, pop_s, full_s, empty_s, ram_we_s;
    logic [31:0]     mmio_data_s;

`ifdef PICO_MEM_TIMER_EN
    logic [31:0]     timer_r;

    // Free-running cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 32'd0;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end
`endif

    assign full_s     = (count_r == DEPTH_C);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign is_write_s = (wstrb_r != 4'd0);
    assign start_s    = (state_r == ST_IDLE) && bus.mem_valid && !mem_ready_r;
    assign commit_s   = (state_r == ST_WAIT) && wait_done_s;
    assign pop_s      = out_valid_r && bus.out_ready;
    assign push_s     = commit_s && is_write_s && (tgt_r == T_OUT);
    assign ram_we_s   = commit_s && is_write_s && (tgt_r == T_RAM);

    // Address decode of the incoming request; MMIO words take priority over RAM.
    always_comb begin
        tgt_s = T_ERR;
        if (bus.mem_addr[31:2] == OUT_ADDR[31:2]) begin
            tgt_s = T_OUT;
        end else if (bus.mem_addr[31:2] == STAT_ADDR[31:2]) begin
            tgt_s = T_STAT;
`ifdef PICO_MEM_TIMER_EN
        end else if (bus.mem_addr[31:2] == TIMER_ADDR[31:2]) begin
            tgt_s = T_TIMER;
`endif
        end else if (bus.mem_addr[31:2] < MEM_WORDS_W) begin
            tgt_s = T_RAM;
        end else begin
            tgt_s = T_ERR;
        end
    end

    // WAIT exit: reads count wait cycles, writes leave at once unless a byte push meets a full FIFO.
    always_comb begin
        wait_done_s = 1'b0;
        if (is_write_s) begin
            if (tgt_r == T_OUT) begin
                wait_done_s = !full_s || pop_s;
            end else begin
                wait_done_s = 1'b1;
            end
        end else begin
            wait_done_s = (wait_cnt_r == WAIT_CYC);
        end
    end

    // Next-state logic for the IDLE -> WAIT -> RESP transaction sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read data for the MMIO targets, sampled on the commit edge.
    always_comb begin
        mmio_data_s = 32'd0;
        case (tgt_r)
            T_STAT:  mmio_data_s = {16'd0, 8'(count_r), 6'd0, full_s, empty_s};
`ifdef PICO_MEM_TIMER_EN
            T_TIMER: mmio_data_s = timer_r;
`endif
            default: mmio_data_s = 32'd0;
        endcase
    end

    // Bus-side registers: request capture, wait counter and the one-cycle response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            tgt_r       <= T_ERR;
            ram_idx_r   <= {AW{1'b0}};
            wdata_r     <= 32'd0;
            wstrb_r     <= 4'd0;
            wait_cnt_r  <= 2'd0;
            mmio_q_r    <= 32'd0;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'd0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                tgt_r      <= tgt_s;
                ram_idx_r  <= bus.mem_addr[AW+1:2];
                wdata_r    <= bus.mem_wdata;
                wstrb_r    <= bus.mem_wstrb;
                wait_cnt_r <= 2'd0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end
            if (commit_s) begin
                mmio_q_r <= mmio_data_s;
            end
            if (state_r == ST_RESP) begin
                mem_ready_r <= 1'b1;
                bus_err_r   <= (tgt_r == T_ERR);
                if (tgt_r == T_ERR) begin
                    mem_rdata_r <= 32'd0;
                end else if (!is_write_s) begin
                    mem_rdata_r <= (tgt_r == T_RAM) ? ram_q_r : mmio_q_r;
                end
            end else begin
                mem_ready_r <= 1'b0;
                bus_err_r   <= 1'b0;
            end
        end
    end

    // RAM array: per-lane writes on the commit edge, registered word read for the response.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_r[b]) begin
                    ram_r[ram_idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
        ram_q_r <= ram_r[ram_idx_r];
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= wdata_r[7:0];
        end
    end

    // Next FIFO read pointer, count and registered head byte.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = out_byte_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // The new head may be the very byte being pushed this cycle.
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = out_byte_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wdata_r[7:0];
        end else begin
            head_nxt_s = fifo_r[rd_ptr_nxt_s];
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_byte_r  <= 8'd0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_byte_r  <= head_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.bus_err   = bus_err_r;
    assign bus.out_byte  = out_byte_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_pico_mem_mmio_slave.sv
// tb_pico_mem_mmio_slave: scoreboard bench for two slaves (READ_WAIT 0 and 3) sharing one
// stimulus path; sel chooses which instance the bus drives and observes.
module tb_pico_mem_mmio_slave;
    localparam logic [31:0] OUT_A  = 32'h1000_0000;
    localparam logic [31:0] STAT_A = 32'h1000_0004;

    typedef struct {
        logic [31:0] rdata;
        bit          cmp_data;
        bit          err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel, valid, out_ready;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        ready_m, err_m, out_valid_m;
    logic [31:0] rdata_m;
    logic [7:0]  out_byte_m;

    int          cyc = 0;
    int          t0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [7:0]  byte_q[$];

    int          ta, tb2;
    logic        stalled;
    logic [31:0] v1, v2, dummy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pico_mem_mmio_slave_if bus0 ();
    pico_mem_mmio_slave_if bus3 ();

    assign bus0.mem_valid = valid && !sel;
    assign bus3.mem_valid = valid && sel;
    assign bus0.mem_instr = 1'b0;
    assign bus3.mem_instr = 1'b0;
    assign bus0.mem_addr  = addr;
    assign bus3.mem_addr  = addr;
    assign bus0.mem_wdata = wdata;
    assign bus3.mem_wdata = wdata;
    assign bus0.mem_wstrb = wstrb;
    assign bus3.mem_wstrb = wstrb;
    assign bus0.out_ready = out_ready && !sel;
    assign bus3.out_ready = out_ready && sel;

    assign ready_m     = sel ? bus3.mem_ready : bus0.mem_ready;
    assign err_m       = sel ? bus3.bus_err   : bus0.bus_err;
    assign rdata_m     = sel ? bus3.mem_rdata : bus0.mem_rdata;
    assign out_valid_m = sel ? bus3.out_valid : bus0.out_valid;
    assign out_byte_m  = sel ? bus3.out_byte  : bus0.out_byte;

    pico_mem_mmio_slave #(.READ_WAIT(0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
    pico_mem_mmio_slave #(.READ_WAIT(3)) dut3 (.clk(clk), .resetn(resetn), .bus(bus3));

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; the next edge samples the request.
    task automatic bus_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] rd, input bit cmp, input bit err, input int lat);
        exp_t e;
        e.rdata = rd; e.cmp_data = cmp; e.err = err; e.lat = lat;
        exp_q.push_back(e);
        addr = a; wdata = d; wstrb = s; valid = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic bus_finish(input string tag, output logic [31:0] got);
        exp_t e;
        for (int k = 0; k < 60 && !ready_m; k++) begin
            @(posedge clk); #1;
        end
        got = rdata_m;
        chk_val({tag, "_ready"}, 32'(ready_m), 32'd1);
        e = exp_q.pop_front();
        valid = 1'b0;
        if (ready_m) begin
            chk_val({tag, "_err"}, 32'(err_m), 32'(e.err));
            if (e.cmp_data) chk_val({tag, "_rdata"}, rdata_m, e.rdata);
            if (e.lat >= 0) chk_val({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
            @(posedge clk); #1;
            chk_val({tag, "_pulse"}, 32'(ready_m), 32'd0);
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd, input bit err, input int lat);
        logic [31:0] got;
        bus_start(a, d, s, rd, (s == 4'h0) || err, err, lat);
        bus_finish(tag, got);
    endtask

    task automatic drain(input string tag, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 20 && !out_valid_m; k++) begin
                @(posedge clk); #1;
            end
            chk_val({tag, "_valid"}, 32'(out_valid_m), 32'd1);
            chk_val({tag, "_byte"}, 32'(out_byte_m), 32'(byte_q.pop_front()));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; valid = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            #1;
            chk_val("rst_ready", 32'(ready_m), 32'd0);
            chk_val("rst_err", 32'(err_m), 32'd0);
            chk_val("rst_rdata", rdata_m, 32'd0);
            chk_val("rst_out_valid", 32'(out_valid_m), 32'd0);
            chk_val("rst_out_byte", 32'(out_byte_m), 32'd0);
        end
        sel = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;

        // T1: byte-strobed RAM write then full-word read on both wait settings
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            xfer("t1_wr_full", 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 2);
            xfer("t1_wr_b1", 32'h10, 32'h5555_5555, 4'h2, 32'd0, 1'b0, 2);
            xfer("t1_rd", 32'h10, 32'd0, 4'h0, 32'hDEAD_55EF, 1'b0, (d == 1) ? 5 : 2);
        end
        sel = 1'b0;

        // T2: fill the FIFO with the sink stalled
        for (int i = 0; i < 8; i++) begin
            byte_q.push_back(8'h41 + 8'(i));
            xfer("t2_push", OUT_A, {24'hABCDEF, 8'h41 + 8'(i)}, 4'h1, 32'd0, 1'b0, 2);
        end
        chk_val("t2_head", 32'(out_byte_m), 32'h41);
        xfer("t2_stat", STAT_A, 32'd0, 4'h0, 32'h0000_0802, 1'b0, 2);

        // T3: push into a full FIFO stalls until one byte drains
        bus_start(OUT_A, 32'h0000_0049, 4'h1, 32'd0, 1'b0, 1'b0, -1);
        stalled = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            stalled = stalled | ready_m;
        end
        chk_val("t3_stall", 32'(stalled), 32'd0);
        out_ready = 1'b1;
        chk_val("t3_first", 32'(out_byte_m), 32'(byte_q.pop_front()));
        byte_q.push_back(8'h49);
        @(posedge clk); #1;
        out_ready = 1'b0;
        bus_finish("t3_wr", dummy);
        drain("t3_drain", 8);
        chk_val("t3_empty", 32'(out_valid_m), 32'd0);
        xfer("t3_stat", STAT_A, 32'd0, 4'h0, 32'h0000_0001, 1'b0, 2);

        // Side cases: OUT read returns zero, STAT write is ignored
        xfer("out_rd", OUT_A, 32'd0, 4'h0, 32'd0, 1'b0, 2);
        xfer("stat_wr", STAT_A, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, 2);
        xfer("stat_rd2", STAT_A, 32'd0, 4'h0, 32'h0000_0001, 1'b0, 2);

        // T4: unmapped read and an aliasing write just past the RAM
        xfer("t4_w0", 32'h0, 32'h1234_5678, 4'hF, 32'd0, 1'b0, 2);
        xfer("t4_r0a", 32'h0, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 2);
        xfer("t4_rd_unmapped", 32'h2000_0000, 32'd0, 4'h0, 32'd0, 1'b1, 2);
        xfer("t4_wr_unmapped", 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 2);
        xfer("t4_r0b", 32'h0, 32'd0, 4'h0, 32'h1234_5678, 1'b0, 2);

        // T6: cycle counter, or bus error when the counter is not built
`ifdef PICO_MEM_TIMER_EN
        bus_start(STAT_A + 32'd4, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0, 2);
        ta = t0;
        bus_finish("t6_rd1", v1);
        repeat (7) @(posedge clk);
        #1;
        xfer("t6_wr_ign", STAT_A + 32'd4, 32'd0, 4'hF, 32'd0, 1'b0, 2);
        bus_start(STAT_A + 32'd4, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0, 2);
        tb2 = t0;
        bus_finish("t6_rd2", v2);
        chk_val("t6_delta", v2 - v1, 32'(tb2 - ta));
`else
        xfer("t6_unmapped", STAT_A + 32'd4, 32'd0, 4'h0, 32'd0, 1'b1, 2);
`endif

        // T5: reset during a slow read with bytes queued
        sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            byte_q.push_back(8'h61 + 8'(i));
            xfer("t5_push", OUT_A, {24'd0, 8'h61 + 8'(i)}, 4'h1, 32'd0, 1'b0, 2);
        end
        chk_val("t5_queued", 32'(out_valid_m), 32'(byte_q.size() != 0));
        bus_start(32'h10, 32'd0, 4'h0, 32'hDEAD_55EF, 1'b1, 1'b0, 5);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk_val("t5_rst_ready", 32'(ready_m), 32'd0);
        chk_val("t5_rst_out_valid", 32'(out_valid_m), 32'd0);
        exp_q.delete();
        byte_q.delete();
        valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        xfer("t5_stat", STAT_A, 32'd0, 4'h0, 32'h0000_0001, 1'b0, 5);
        xfer("t5_ram_kept", 32'h10, 32'd0, 4'h0, 32'hDEAD_55EF, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
